// File: rtl/trace_pkg.sv
// Shared record format for the register-file / sequencer activity tracer.
// Widths mirror the rf_trace_monitor parameter defaults.
package trace_pkg;

    localparam int unsigned TRACE_NUM_PORTS   = 4;
    localparam int unsigned TRACE_ADDR_WIDTH  = 6;
    localparam int unsigned TRACE_DATA_WIDTH  = 16;
    localparam int unsigned TRACE_PC_WIDTH    = 6;
    localparam int unsigned TRACE_INSTR_WIDTH = 27;
    localparam int unsigned TRACE_TS_WIDTH    = 32;

    localparam int unsigned REC_PORT_W = $clog2(TRACE_NUM_PORTS + 1);
    localparam int unsigned REC_ADDR_W =
        (TRACE_ADDR_WIDTH > TRACE_PC_WIDTH) ? TRACE_ADDR_WIDTH : TRACE_PC_WIDTH;
    localparam int unsigned REC_DATA_W =
        (TRACE_DATA_WIDTH > TRACE_INSTR_WIDTH) ? TRACE_DATA_WIDTH : TRACE_INSTR_WIDTH;

    typedef enum logic {
        REC_PC   = 1'b0,
        REC_PORT = 1'b1
    } rec_kind_e;

    typedef struct packed {
        rec_kind_e               kind;
        logic [REC_PORT_W-1:0]   port;
        logic [REC_ADDR_W-1:0]   addr;
        logic [REC_DATA_W-1:0]   data;
        logic [TRACE_TS_WIDTH-1:0] ts;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO; a push into a full FIFO is legal when a pop happens on the same edge.
// Head reads as zero while empty.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_empty;

    assign w_empty = (r_wptr == r_rptr);
    assign o_empty = w_empty;
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_dout  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/rf_trace_monitor.sv
// Per-cell tracer: captures PC changes and register-file port accesses into pending slots,
// drains them by fixed priority into a record FIFO, and accounts for lost events.
module rf_trace_monitor
    import trace_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PC_WIDTH    = 6,
    parameter int unsigned INSTR_WIDTH = 27,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TS_WIDTH    = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic [NUM_PORTS-1:0]             addr_en,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data,
    input  logic [PC_WIDTH-1:0]              pc,
    input  logic [INSTR_WIDTH-1:0]           instr,
    output logic                             rec_valid,
    input  logic                             rec_ready,
    output trace_rec_t                       rec,
    output logic [15:0]                      drop_count,
    output logic                             overflow
);

    localparam int unsigned NUM_SLOTS = NUM_PORTS + 1;
    localparam int unsigned CNT_W     = $clog2(NUM_SLOTS + 1);

    logic [TS_WIDTH-1:0]  r_ts;
    logic                 r_pc_seen;
    logic [PC_WIDTH-1:0]  r_last_pc;
    logic [NUM_SLOTS-1:0] r_slot_vld;
    trace_rec_t           r_slot_rec [NUM_SLOTS];
    logic [15:0]          r_drop_count;
    logic                 r_overflow;

    logic [NUM_SLOTS-1:0] w_evt;
    logic [NUM_SLOTS-1:0] w_grant;
    logic [NUM_SLOTS-1:0] w_drop;
    trace_rec_t           w_new_rec [NUM_SLOTS];
    trace_rec_t           w_push_rec;
    logic                 w_accept;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic [REC_W-1:0]     w_dout;
    logic [CNT_W-1:0]     w_drop_n;
    logic [16:0]          w_drop_sum;

    assign w_pop      = rec_valid && rec_ready;
    assign w_accept   = !w_full || w_pop;
    assign rec_valid  = !w_empty;
    assign rec        = trace_rec_t'(w_dout);
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;

    // Slot 0 is the PC detector, slot i+1 is register-file port i.
    always_comb begin
        w_evt[0]            = enable && (!r_pc_seen || (pc != r_last_pc));
        w_new_rec[0].kind   = REC_PC;
        w_new_rec[0].port   = '0;
        w_new_rec[0].addr   = REC_ADDR_W'(pc);
        w_new_rec[0].data   = REC_DATA_W'(instr);
        w_new_rec[0].ts     = TRACE_TS_WIDTH'(r_ts);
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_evt[i+1]          = enable && addr_en[i];
            w_new_rec[i+1].kind = REC_PORT;
            w_new_rec[i+1].port = REC_PORT_W'(i);
            w_new_rec[i+1].addr = REC_ADDR_W'(addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            w_new_rec[i+1].data = REC_DATA_W'(data[i*DATA_WIDTH +: DATA_WIDTH]);
            w_new_rec[i+1].ts   = TRACE_TS_WIDTH'(r_ts);
        end
    end

    always_comb begin
        logic found;
        found      = 1'b0;
        w_grant    = '0;
        w_push_rec = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (w_accept && r_slot_vld[s] && !found) begin
                found      = 1'b1;
                w_grant[s] = 1'b1;
                w_push_rec = r_slot_rec[s];
            end
        end
    end

    always_comb begin
        w_drop_n = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            w_drop[s] = w_evt[s] && r_slot_vld[s] && !w_grant[s];
            w_drop_n  = w_drop_n + CNT_W'(w_drop[s]);
        end
        w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts         <= '0;
            r_pc_seen    <= 1'b0;
            r_last_pc    <= '0;
            r_slot_vld   <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) r_slot_rec[s] <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (enable) begin
                r_pc_seen <= 1'b1;
                r_last_pc <= pc;
            end
            // A slot drained this edge can be reloaded without loss.
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (w_evt[s] && (!r_slot_vld[s] || w_grant[s])) begin
                    r_slot_vld[s] <= 1'b1;
                    r_slot_rec[s] <= w_new_rec[s];
                end else if (w_grant[s]) begin
                    r_slot_vld[s] <= 1'b0;
                end
            end
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (|w_drop) r_overflow <= 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (|w_grant),
        .i_din   (w_push_rec),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_rf_trace_monitor.sv
// Scoreboard bench for rf_trace_monitor: directed stimulus pushes expected records,
// a separate monitor pops and compares on every accepted head record.
module tb_rf_trace_monitor;
    import trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  addr_en;
    logic [23:0] addr;
    logic [63:0] data;
    logic [5:0]  pc;
    logic [26:0] instr;
    logic        rec_valid;
    logic        rec_ready;
    trace_rec_t  rec;
    logic [15:0] drop_count;
    logic        overflow;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc;
    trace_rec_t  exp_q [$];

    always #5 clk = ~clk;

    // Reference time base: cycles since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    rf_trace_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .addr_en    (addr_en),
        .addr       (addr),
        .data       (data),
        .pc         (pc),
        .instr      (instr),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec        (rec),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    function automatic trace_rec_t mk(rec_kind_e k, int unsigned p, int unsigned a,
                                      int unsigned d, int unsigned t);
        trace_rec_t r;
        r.kind = k;
        r.port = REC_PORT_W'(p);
        r.addr = REC_ADDR_W'(a);
        r.data = REC_DATA_W'(d);
        r.ts   = TRACE_TS_WIDTH'(t);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        trace_rec_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rec_valid && rec_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rec: got=%0h want=none", rec);
                end else begin
                    e = exp_q.pop_front();
                    chk("rec", rec, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; addr_en = '0; addr = '0; data = '0;
        pc = '0; instr = '0; rec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", rec_valid, 0);
        chk("reset_rec", rec, 0);
        chk("reset_drop", drop_count, 0);
        chk("reset_ovf", overflow, 0);

        // First enabled cycle emits one PC record, visible two cycles later.
        rst_n = 1'b1; enable = 1'b1; pc = 6'd5; instr = 27'h0ABCDEF; rec_ready = 1'b1;
        exp_q.push_back(mk(REC_PC, 0, 5, 27'h0ABCDEF, 0));
        @(negedge clk); chk("pc_lat_c0", rec_valid, 0);
        tick(); @(negedge clk); chk("pc_lat_c1", rec_valid, 0);
        tick(); @(negedge clk); chk("pc_lat_c2", rec_valid, 1);
        repeat (6) tick();
        chk("pc_once_q", exp_q.size(), 0);
        chk("pc_quiet", rec_valid, 0);

        // All four ports in one cycle: drained in port order on consecutive cycles.
        addr    = {6'd12, 6'd9, 6'd7, 6'd3};
        data    = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
        addr_en = 4'b1111;
        exp_q.push_back(mk(REC_PORT, 0, 3,  16'hA000, cyc));
        exp_q.push_back(mk(REC_PORT, 1, 7,  16'hB001, cyc));
        exp_q.push_back(mk(REC_PORT, 2, 9,  16'hC002, cyc));
        exp_q.push_back(mk(REC_PORT, 3, 12, 16'hD003, cyc));
        tick();
        addr_en = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("burst_valid", rec_valid, 1);
            tick();
        end
        @(negedge clk); chk("burst_end", rec_valid, 0);
        chk("burst_q", exp_q.size(), 0);

        // Stalled consumer: 16 in FIFO, 1 in slot, 3 dropped.
        rec_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            addr    = 24'(i);
            data    = 64'(16'h0100 + i);
            addr_en = 4'b0001;
            if (i <= 17) exp_q.push_back(mk(REC_PORT, 0, i, 16'h0100 + i, cyc));
            tick();
        end
        addr_en = '0;
        tick(); tick();
        chk("stall_drop", drop_count, 3);
        chk("stall_ovf", overflow, 1);
        chk("stall_valid", rec_valid, 1);
        chk("stall_head0", rec, exp_q[0]);
        tick();
        chk("stall_head1", rec, exp_q[0]);
        rec_ready = 1'b1;
        repeat (22) tick();
        chk("stall_q", exp_q.size(), 0);
        chk("stall_empty", rec_valid, 0);

        // Full FIFO + pending slot: pop and new event on the same edge, no drop.
        rec_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            addr    = 24'(30 + i);
            data    = 64'(16'h0200 + i);
            addr_en = 4'b0001;
            exp_q.push_back(mk(REC_PORT, 0, 30 + i, 16'h0200 + i, cyc));
            tick();
        end
        addr_en = '0;
        tick();
        rec_ready = 1'b1;
        addr      = 24'd50;
        data      = 64'h02FF;
        addr_en   = 4'b0001;
        exp_q.push_back(mk(REC_PORT, 0, 50, 16'h02FF, cyc));
        tick();
        addr_en = '0;
        repeat (22) tick();
        chk("reload_drop", drop_count, 3);
        chk("reload_q", exp_q.size(), 0);

        // Reset mid-stream discards queued records without counting them.
        rec_ready = 1'b0;
        addr      = {6'd0, 6'd0, 6'd21, 6'd0};
        addr_en   = 4'b0010;
        repeat (10) tick();
        addr_en = '0;
        tick(); tick();
        chk("pre_rst_valid", rec_valid, 1);
        rst_n = 1'b0;
        #2;
        chk("rst_valid", rec_valid, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_ovf", overflow, 0);
        tick();
        rst_n = 1'b1; rec_ready = 1'b1; instr = 27'h1234567;
        exp_q.push_back(mk(REC_PC, 0, 5, 27'h1234567, 0));
        repeat (5) tick();
        chk("post_rst_q", exp_q.size(), 0);
        chk("post_rst_drop", drop_count, 0);

        // Disabled: no captures at all; re-enable emits only if pc differs from last_pc.
        enable  = 1'b0;
        addr_en = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            pc = 6'(10 + k);
            tick();
        end
        addr_en = '0;
        pc      = 6'd9;
        enable  = 1'b1;
        exp_q.push_back(mk(REC_PC, 0, 9, 27'h1234567, cyc));
        repeat (5) tick();
        chk("reen_q", exp_q.size(), 0);
        enable = 1'b0;
        pc     = 6'd20;
        tick(); tick();
        pc     = 6'd9;
        enable = 1'b1;
        repeat (5) tick();
        chk("reen_same_valid", rec_valid, 0);
        chk("reen_same_drop", drop_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
